// File: rtl/iir8_requant.sv
// 8-lane requantizer: round-half-up arithmetic shift, saturate to NOUTBITS, and
// per-window saturation counting with the shift held constant across each window.
module iir8_requant #(
    parameter int NSAMP         = 8,
    parameter int NINBITS       = 24,
    parameter int NOUTBITS      = 12,
    parameter int SHIFT_DEFAULT = 10,
    parameter int WINDOW_LOG2   = 20,
    parameter int CNT_BITS      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NSAMP*NINBITS-1:0]    din,
    input  logic                        din_valid,
    input  logic [4:0]                  shift_in,
    input  logic                        shift_wr,
    output logic [NSAMP*NOUTBITS-1:0]   dout,
    output logic                        dout_valid,
    output logic [CNT_BITS-1:0]         sat_count,
    output logic                        sat_count_valid,
    output logic [4:0]                  shift_active
);
    localparam int SW = NINBITS + 1;
    localparam int PW = $clog2(NSAMP + 1);
    localparam logic signed [SW-1:0] OMAX = SW'(2**(NOUTBITS-1) - 1);
    localparam logic signed [SW-1:0] OMIN = ~OMAX;

    logic [4:0]             pend_q, act_q, wr_val;
    logic [WINDOW_LOG2-1:0] win_q;
    logic                   last_in;

    assign wr_val  = (shift_in > 5'd23) ? 5'd23 : shift_in;
    assign last_in = din_valid && (win_q == '1);

    // A write landing on the boundary cycle bypasses pending straight into active.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 5'(SHIFT_DEFAULT);
            act_q  <= 5'(SHIFT_DEFAULT);
            win_q  <= '0;
        end else begin
            if (shift_wr)  pend_q <= wr_val;
            if (last_in)   act_q  <= shift_wr ? wr_val : pend_q;
            if (din_valid) win_q  <= win_q + 1'b1;
        end
    end

    // Stage 1: add rounding constant at full precision
    logic [SW-1:0]             rnd;
    logic [NSAMP-1:0][SW-1:0]  sum_d, sum_q;
    logic [4:0]                s1_sh_q;
    logic                      s1_vld_q, s1_last_q;

    assign rnd = (act_q == 5'd0) ? '0 : (SW'(1) << (act_q - 5'd1));

    // Stage 2: shift and clip
    logic [NSAMP-1:0][NOUTBITS-1:0] out_d;
    logic [NSAMP-1:0]               flag_d;

    for (genvar k = 0; k < NSAMP; k++) begin : g_lane
        logic signed [SW-1:0] y;
        logic                 hi, lo;
        assign sum_d[k] = {din[NINBITS*k+NINBITS-1], din[NINBITS*k +: NINBITS]} + rnd;
        assign y        = $signed(sum_q[k]) >>> s1_sh_q;
        assign hi       = y > OMAX;
        assign lo       = y < OMIN;
        assign flag_d[k] = hi | lo;
        assign out_d[k]  = hi ? OMAX[NOUTBITS-1:0] : (lo ? OMIN[NOUTBITS-1:0] : y[NOUTBITS-1:0]);
    end

    logic [PW-1:0]       pop_d;
    logic [CNT_BITS:0]   acc_sum;
    logic [CNT_BITS-1:0] acc_q, acc_sat, sat_count_q;
    logic [NSAMP-1:0][NOUTBITS-1:0] dout_q;
    logic                dout_valid_q, sat_valid_q;

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < NSAMP; i++) pop_d = pop_d + PW'(flag_d[i]);
    end

    assign acc_sum = {1'b0, acc_q} + (CNT_BITS+1)'(pop_d);
    assign acc_sat = acc_sum[CNT_BITS] ? '1 : acc_sum[CNT_BITS-1:0];

    always_ff @(posedge clk) begin
        sum_q   <= sum_d;
        s1_sh_q <= act_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sat_valid_q  <= 1'b0;
            sat_count_q  <= '0;
            acc_q        <= '0;
        end else begin
            s1_vld_q     <= din_valid;
            s1_last_q    <= last_in;
            dout_valid_q <= s1_vld_q;
            sat_valid_q  <= s1_vld_q && s1_last_q;
            if (s1_vld_q) begin
                dout_q <= out_d;
                acc_q  <= s1_last_q ? '0 : acc_sat;
                if (s1_last_q) sat_count_q <= acc_sat;
            end
        end
    end

    assign dout            = dout_q;
    assign dout_valid      = dout_valid_q;
    assign sat_count       = sat_count_q;
    assign sat_count_valid = sat_valid_q;
    assign shift_active    = act_q;
endmodule

// File: tb/tb_iir8_requant.sv
// Directed + randomized bench for iir8_requant against a per-beat arithmetic model
// (16-beat windows, 6-bit saturation counter).
module tb_iir8_requant;
    localparam int NS = 8, NI = 24, NO = 12, WL = 4, CB = 6, SD = 10;
    localparam int CMAX = (1 << CB) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*NI-1:0]  din;
    logic              din_valid;
    logic [4:0]        shift_in;
    logic              shift_wr;
    logic [NS*NO-1:0]  dout;
    logic              dout_valid;
    logic [CB-1:0]     sat_count;
    logic              sat_count_valid;
    logic [4:0]        shift_active;

    always #5 clk = ~clk;

    iir8_requant #(.NSAMP(NS), .NINBITS(NI), .NOUTBITS(NO), .SHIFT_DEFAULT(SD),
                   .WINDOW_LOG2(WL), .CNT_BITS(CB)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .shift_in(shift_in), .shift_wr(shift_wr), .dout(dout), .dout_valid(dout_valid),
        .sat_count(sat_count), .sat_count_valid(sat_count_valid), .shift_active(shift_active));

    typedef struct packed {
        logic             vld;
        logic [NS*NO-1:0] dout;
        logic             pulse;
        logic [CB-1:0]    satc;
    } rec_t;

    rec_t exp_q[$];
    int   m_pend, m_act, m_idx, m_acc, m_satc;
    int   vectors = 0, fails = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] lane_o(int k);
        return 32'($signed(dout[NO*k +: NO]));
    endfunction

    function automatic int clampsh(int s);
        return (s > 23) ? 23 : s;
    endfunction

    // Round half up = floor(x/2^s + 1/2), then clip to the output range.
    function automatic int rq(int x, int s, output bit clip);
        real r;
        int  y;
        r = $floor(real'(x) / (2.0 ** s) + 0.5);
        y = int'(r);
        clip = (y > 2047) || (y < -2048);
        if (y > 2047) y = 2047;
        if (y < -2048) y = -2048;
        return y;
    endfunction

    function automatic logic [NS*NI-1:0] pack8(int a0, int a1, int a2, int a3,
                                              int a4, int a5, int a6, int a7);
        logic [NS*NI-1:0] d;
        d = {a7[NI-1:0], a6[NI-1:0], a5[NI-1:0], a4[NI-1:0],
             a3[NI-1:0], a2[NI-1:0], a1[NI-1:0], a0[NI-1:0]};
        return d;
    endfunction

    function automatic int rnd_lane();
        int v;
        case ($urandom_range(0, 2))
            0:       v = int'($urandom_range(0, 16777215)) - 8388608;
            1:       v = int'($urandom_range(0, 8191)) - 4096;
            default: v = ($urandom_range(0, 1) != 0) ? 5000000 : -5000000;
        endcase
        return v;
    endfunction

    function automatic logic [NS*NI-1:0] rnd_vec();
        logic [NS*NI-1:0] d;
        int v;
        for (int k = 0; k < NS; k++) begin
            v = rnd_lane();
            d[NI*k +: NI] = v[NI-1:0];
        end
        return d;
    endfunction

    task automatic step(input logic [NS*NI-1:0] d, input bit v, input bit wr, input int sh);
        rec_t r, e;
        int   c, x, y;
        bit   cl;
        din = d; din_valid = v; shift_in = sh[4:0]; shift_wr = wr;
        r = '0;
        r.vld = v;
        if (v) begin
            c = 0;
            for (int k = 0; k < NS; k++) begin
                x = int'($signed(d[NI*k +: NI]));
                y = rq(x, m_act, cl);
                if (cl) c++;
                r.dout[NO*k +: NO] = y[NO-1:0];
            end
            m_acc = (m_acc + c > CMAX) ? CMAX : m_acc + c;
        end
        if (wr) m_pend = clampsh(sh);
        if (v) begin
            if (m_idx == (1 << WL) - 1) begin
                m_satc = m_acc; m_acc = 0; m_idx = 0; r.pulse = 1'b1; m_act = m_pend;
            end else m_idx++;
        end
        r.satc = m_satc[CB-1:0];
        exp_q.push_back(r);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk("dout_valid", dout_valid, e.vld);
        if (e.vld) chk("dout", dout, e.dout);
        chk("sat_count_valid", sat_count_valid, e.pulse);
        chk("sat_count", sat_count, e.satc);
        chk("shift_active", shift_active, m_act);
    endtask

    task automatic do_reset();
        rec_t idle;
        rst = 1'b1; din_valid = 1'b0; shift_wr = 1'b0; shift_in = '0; din = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        m_pend = SD; m_act = SD; m_idx = 0; m_acc = 0; m_satc = 0;
        exp_q.delete();
        idle = '0;
        exp_q.push_back(idle);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_sat_valid", sat_count_valid, 0);
        chk("rst_shift_active", shift_active, SD);
    endtask

    initial begin
        logic [NS*NI-1:0] t1, t2, clip3, clip8, clip2, b4;
        t1    = pack8(3072, 512, -512, -513, 1535, 0, 0, 0);
        t2    = pack8(5000, -5000, 2047, -2048, 2048, -2049, 0, 1);
        clip3 = pack8(5000000, -5000000, 5000000, 1000, -1000, 0, 7, 2047);
        clip8 = pack8(5000000, -5000000, 5000000, -5000000, 8388607, -8388608, 5000000, -5000000);
        clip2 = pack8(5000000, -5000000, 100, 200, 300, -400, 0, 1);
        b4    = pack8(100000, 0, 0, 0, 0, 0, 0, 0);

        // 1: rounding at s=10, latency and bubbles
        do_reset();
        step(t1, 1, 0, 0);
        step('0, 0, 0, 0);
        chk("t1_l0", lane_o(0), 3);
        chk("t1_l1", lane_o(1), 1);
        chk("t1_l2", lane_o(2), 0);
        chk("t1_l3", lane_o(3), -1);
        chk("t1_l4", lane_o(4), 1);
        step(t1, 1, 0, 0); step('0, 0, 0, 0); step(t1, 1, 0, 0); step(t1, 1, 0, 0);
        step('0, 0, 0, 0); step('0, 0, 0, 0);

        // 2: saturation at s=0 (shift takes effect after one full window)
        do_reset();
        step('0, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(rnd_vec(), 1, 0, 0);
        chk("t2_shift0", shift_active, 0);
        step(t2, 1, 0, 0);
        step('0, 0, 0, 0);
        chk("t2_l0", lane_o(0), 2047);
        chk("t2_l1", lane_o(1), -2048);
        chk("t2_l2", lane_o(2), 2047);
        chk("t2_l3", lane_o(3), -2048);
        chk("t2_l4", lane_o(4), 2047);
        chk("t2_l5", lane_o(5), -2048);
        chk("t2_l6", lane_o(6), 0);
        chk("t2_l7", lane_o(7), 1);

        // 3: one window, gaps, 3 clipped lanes per beat
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(clip3, 1, 0, 0);
            if (i % 3 == 1) step('0, 0, 0, 0);
        end
        step('0, 0, 0, 0); step('0, 0, 0, 0);
        chk("t3_sat_count", sat_count, 48);

        // 4: shift update at window boundary
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            step(b4, 1, i == 5, 4);
            if (i == 5) chk("t4_act_b5", shift_active, 10);
        end
        step(b4, 1, 1, 6);
        chk("t4_act_b16", shift_active, 6);
        step(b4, 1, 0, 0);
        chk("t4_b16_s10", lane_o(0), 98);
        step('0, 0, 0, 0);
        chk("t4_b17_s6", lane_o(0), 1563);

        // 5: counter saturation, then a back-to-back first beat
        do_reset();
        for (int i = 0; i < 16; i++) step(clip8, 1, 0, 0);
        step(clip8, 1, 0, 0);
        step('0, 0, 0, 0);
        chk("t5_sat_count", sat_count, CMAX);

        // 6: reset in place of beat 9 discards the partial window
        do_reset();
        for (int i = 1; i <= 8; i++) step(clip3, 1, i == 2, 3);
        do_reset();
        for (int i = 0; i < 16; i++) step(clip2, 1, 0, 0);
        step('0, 0, 0, 0); step('0, 0, 0, 0);
        chk("t6_sat_count", sat_count, 32);

        // Randomized traffic with random shift writes
        do_reset();
        for (int i = 0; i < 400; i++)
            step(rnd_vec(), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, 31)));
        step('0, 0, 0, 0); step('0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
